// File: rtl/ili9341_cmd_sequencer.sv
// ILI9341 link controller: panel reset pulse, init ROM walk, then RGB565 pixel streaming.
// Every byte goes to an external SPI shifter through a load/done handshake.
module ili9341_cmd_sequencer #(
    parameter int unsigned ROM_DEPTH        = 48,
    parameter int unsigned RST_LOW_CYC      = 16,
    parameter int unsigned RST_WAIT_CYC     = 32,
    parameter int unsigned SLPOUT_WAIT_CYC  = 64,
    parameter int unsigned PIXELS_PER_FRAME = 76800
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    output logic [$clog2(ROM_DEPTH)-1:0] rom_addr_o,
    input  logic [9:0]                   rom_data_i,
    output logic [7:0]                   byte_data_o,
    output logic                         byte_dc_o,
    output logic                         byte_load_o,
    input  logic                         byte_done_i,
    input  logic [15:0]                  pix_data_i,
    input  logic                         pix_valid_i,
    output logic                         pix_ready_o,
    output logic                         lcd_rst_n_o,
    output logic                         init_done_o,
    output logic                         frame_start_o
);

    localparam int unsigned AW       = $clog2(ROM_DEPTH);
    localparam int unsigned DlyMax01 = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int unsigned DlyMax   = (DlyMax01 > SLPOUT_WAIT_CYC) ? DlyMax01 : SLPOUT_WAIT_CYC;
    localparam int unsigned DW       = $clog2(DlyMax) + 1;
    localparam int unsigned PW       = $clog2(PIXELS_PER_FRAME) + 1;

    // The INIT_FETCH cycle that follows a wait state completes the wait, so exit one early.
    localparam logic [DW-1:0] RstLowLast  = DW'(RST_LOW_CYC - 1);
    localparam logic [DW-1:0] RstWaitLast = DW'((RST_WAIT_CYC >= 2) ? RST_WAIT_CYC - 2 : 0);
    localparam logic [DW-1:0] SlpLast     = DW'((SLPOUT_WAIT_CYC >= 2) ? SLPOUT_WAIT_CYC - 2 : 0);
    localparam logic [PW-1:0] PixFrame    = PW'(PIXELS_PER_FRAME);
    localparam logic [AW-1:0] RomLast     = AW'(ROM_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle, StHwRst, StRstWait, StInitFetch, StInitWait, StSlpWait, StStream
    } state_e;

    typedef enum logic [1:0] {PhIdle, PhHiBusy, PhLoBusy, PhCmdBusy} phase_e;

    state_e          state_q;
    phase_e          phase_q;
    logic [DW-1:0]   dly_q;
    logic [PW-1:0]   pix_cnt_q;
    logic [AW-1:0]   rom_addr_q;
    logic [7:0]      byte_data_q;
    logic            byte_dc_q;
    logic            byte_load_q;
    logic [7:0]      pix_lo_q;
    logic            pix_ready_q;
    logic            lcd_rst_n_q;
    logic            init_done_q;
    logic            frame_start_q;
    logic            unused_loop_flag;

    assign unused_loop_flag = rom_data_i[9];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            phase_q       <= PhIdle;
            dly_q         <= '0;
            pix_cnt_q     <= '0;
            rom_addr_q    <= RomLast;
            byte_data_q   <= 8'h00;
            byte_dc_q     <= 1'b0;
            byte_load_q   <= 1'b0;
            pix_lo_q      <= 8'h00;
            pix_ready_q   <= 1'b0;
            lcd_rst_n_q   <= 1'b0;
            init_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            byte_load_q   <= 1'b0;
            frame_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        dly_q   <= '0;
                        state_q <= StHwRst;
                    end
                end
                StHwRst: begin
                    if (dly_q == RstLowLast) begin
                        dly_q       <= '0;
                        lcd_rst_n_q <= 1'b1;
                        state_q     <= StRstWait;
                    end else begin
                        dly_q <= dly_q + 1'b1;
                    end
                end
                StRstWait: begin
                    if (dly_q == RstWaitLast) begin
                        dly_q   <= '0;
                        state_q <= StInitFetch;
                    end else begin
                        dly_q <= dly_q + 1'b1;
                    end
                end
                StInitFetch: begin
                    if (rom_data_i[8:0] == 9'h0FF || rom_addr_q == '0) begin
                        state_q       <= StStream;
                        phase_q       <= PhIdle;
                        init_done_q   <= 1'b1;
                        frame_start_q <= 1'b1;
                        pix_cnt_q     <= '0;
                        pix_ready_q   <= 1'b1;
                    end else begin
                        byte_data_q <= rom_data_i[7:0];
                        byte_dc_q   <= rom_data_i[8];
                        byte_load_q <= 1'b1;
                        state_q     <= StInitWait;
                    end
                end
                StInitWait: begin
                    if (byte_done_i) begin
                        rom_addr_q <= rom_addr_q - 1'b1;
                        if (!byte_dc_q && byte_data_q == 8'h11) begin
                            dly_q   <= '0;
                            state_q <= StSlpWait;
                        end else begin
                            state_q <= StInitFetch;
                        end
                    end
                end
                StSlpWait: begin
                    if (dly_q == SlpLast) begin
                        dly_q   <= '0;
                        state_q <= StInitFetch;
                    end else begin
                        dly_q <= dly_q + 1'b1;
                    end
                end
                StStream: begin
                    unique case (phase_q)
                        PhIdle: begin
                            if (pix_cnt_q == PixFrame) begin
                                byte_data_q   <= 8'h2C;
                                byte_dc_q     <= 1'b0;
                                byte_load_q   <= 1'b1;
                                frame_start_q <= 1'b1;
                                pix_cnt_q     <= '0;
                                pix_ready_q   <= 1'b0;
                                phase_q       <= PhCmdBusy;
                            end else if (pix_valid_i && pix_ready_q) begin
                                byte_data_q <= pix_data_i[15:8];
                                byte_dc_q   <= 1'b1;
                                byte_load_q <= 1'b1;
                                pix_lo_q    <= pix_data_i[7:0];
                                pix_ready_q <= 1'b0;
                                phase_q     <= PhHiBusy;
                            end
                        end
                        PhHiBusy: begin
                            // Low byte goes out the cycle after the high byte completes.
                            if (byte_done_i) begin
                                byte_data_q <= pix_lo_q;
                                byte_dc_q   <= 1'b1;
                                byte_load_q <= 1'b1;
                                phase_q     <= PhLoBusy;
                            end
                        end
                        PhLoBusy: begin
                            if (byte_done_i) begin
                                pix_cnt_q   <= pix_cnt_q + 1'b1;
                                pix_ready_q <= (pix_cnt_q + 1'b1) != PixFrame;
                                phase_q     <= PhIdle;
                            end
                        end
                        PhCmdBusy: begin
                            if (byte_done_i) begin
                                pix_ready_q <= 1'b1;
                                phase_q     <= PhIdle;
                            end
                        end
                    endcase
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rom_addr_o    = rom_addr_q;
    assign byte_data_o   = byte_data_q;
    assign byte_dc_o     = byte_dc_q;
    assign byte_load_o   = byte_load_q;
    assign pix_ready_o   = pix_ready_q;
    assign lcd_rst_n_o   = lcd_rst_n_q;
    assign init_done_o   = init_done_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_ili9341_cmd_sequencer.sv
// Directed bench for ili9341_cmd_sequencer with a behavioural SPI shifter and test ROM.
module tb_ili9341_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [5:0]  rom_addr;
    logic [9:0]  rom_data;
    logic [7:0]  byte_data;
    logic        byte_dc, byte_load, byte_done;
    logic [15:0] pix_data;
    logic        pix_valid, pix_ready, lcd_rst_n, init_done, frame_start;

    logic [9:0]  rom [48];
    logic [8:0]  lq [$];
    logic [8:0]  exp_q [$];
    int          lcq [$];
    int          dq [$];
    int total = 0, bad = 0, cyc = 0;
    int last_done = 0, overlap = 0, ready_viol = 0, fs_cnt = 0, fs_cmd = 0;
    int shift_dly = 3;
    bit rand_dly = 1'b0, spur_req = 1'b0;

    ili9341_cmd_sequencer #(
        .ROM_DEPTH(48), .RST_LOW_CYC(4), .RST_WAIT_CYC(6),
        .SLPOUT_WAIT_CYC(10), .PIXELS_PER_FRAME(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .byte_data_o(byte_data), .byte_dc_o(byte_dc), .byte_load_o(byte_load),
        .byte_done_i(byte_done),
        .pix_data_i(pix_data), .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
        .lcd_rst_n_o(lcd_rst_n), .init_done_o(init_done), .frame_start_o(frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rom_data = rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input string tag, input int n, input int bound);
        int k = 0;
        while (lq.size() < n && k < bound) begin
            step();
            k++;
        end
        chk(tag, lq.size(), n);
    endtask

    task automatic wait_init(output int at_cyc);
        int k = 0;
        while (!init_done && k < 5000) begin
            step();
            k++;
        end
        at_cyc = cyc;
        chk("init_done_rise", {31'b0, init_done}, 1);
    endtask

    task automatic send_pix(input logic [15:0] px, input int gap);
        int k = 0;
        pix_valid = 1'b0;
        repeat (gap) step();
        pix_data  = px;
        pix_valid = 1'b1;
        while (!pix_ready && k < 500) begin
            step();
            k++;
        end
        chk("pix_wait", {31'b0, pix_ready}, 1);
        step();
        pix_valid = 1'b0;
    endtask

    // Shifter model: logs each load, returns byte_done after a programmable delay.
    initial begin : shifter
        int  cd;
        bit  busy, was_busy;
        busy = 1'b0;
        cd = 0;
        byte_done = 1'b0;
        forever begin
            step();
            byte_done = 1'b0;
            was_busy = busy;
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (cd <= 1) begin
                        byte_done = 1'b1;
                        busy = 1'b0;
                        dq.push_back(cyc);
                        last_done = cyc;
                    end else begin
                        cd--;
                    end
                end else if (spur_req && !byte_load) begin
                    byte_done = 1'b1;
                    spur_req = 1'b0;
                end
                if (byte_load) begin
                    if (was_busy) overlap++;
                    lq.push_back({byte_dc, byte_data});
                    lcq.push_back(cyc);
                    busy = 1'b1;
                    cd = rand_dly ? int'($urandom_range(1, 20)) : shift_dly;
                    if (frame_start && {byte_dc, byte_data} == 9'h02C) fs_cmd++;
                end
                if (frame_start) fs_cnt++;
                if (pix_ready && busy) ready_viol++;
            end
        end
    end

    initial begin : main
        int k, init_cyc, s, n_term, base;
        logic [8:0] px_exp [9];
        logic [15:0] px;

        for (int i = 0; i < 48; i++) begin
            if (i % 4 == 0) rom[i] = {2'b00, 8'(8'h40 + i)};
            else            rom[i] = {2'b01, 8'(i * 3)};
        end
        rom[47] = 10'h0CB;
        rom[30] = 10'h011;
        rom[20] = 10'h3FF;
        rom[1]  = 10'h02C;
        rom[0]  = 10'h0FF;

        rst_n = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_data = 16'h0000;
        repeat (3) step();
        chk("rst_rom_addr", rom_addr, 47);
        chk("rst_lcd_rst_n", lcd_rst_n, 0);
        chk("rst_byte_load", byte_load, 0);
        chk("rst_byte", {byte_dc, byte_data}, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_frame_start", frame_start, 0);

        rst_n = 1'b1;
        repeat (2) step();
        chk("idle_hold_rst", lcd_rst_n, 0);
        chk("idle_no_load", lq.size(), 0);

        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!lcd_rst_n && k < 50) begin step(); k++; end
        chk("rst_low_cycles", k, 4);
        k = 0;
        while (!byte_load && k < 50) begin step(); k++; end
        chk("rst_wait_cycles", k, 6);
        chk("first_byte", {byte_dc, byte_data}, 9'h0CB);

        wait_init(init_cyc);
        chk("init_count", lq.size(), 47);
        for (int i = 0; i < 47 && i < lq.size(); i++) chk("init_byte", lq[i], rom[47 - i][8:0]);
        n_term = 0;
        foreach (lq[i]) if (lq[i] == 9'h0FF) n_term++;
        chk("no_terminator", n_term, 0);
        chk("init_done_lat", init_cyc - last_done, 2);
        chk("fs_on_entry", frame_start, 1);
        s = 47 - 30;
        chk("slpout_gap", lcq[s + 1] - dq[s], 11);

        px_exp = '{9'h1F8, 9'h100, 9'h107, 9'h1E0, 9'h100, 9'h11F, 9'h02C, 9'h1FF, 9'h1FF};
        send_pix(16'hF800, 0);
        send_pix(16'h07E0, 0);
        send_pix(16'h001F, 0);
        send_pix(16'hFFFF, 0);
        wait_log("pix_log", 56, 500);
        for (int i = 0; i < 9; i++) chk("pix_byte", lq[47 + i], px_exp[i]);
        chk("fs_count", fs_cnt, 2);
        chk("fs_with_2c", fs_cmd, 1);

        repeat (10) step();
        spur_req = 1'b1;
        repeat (10) step();
        chk("spurious_done", lq.size(), 56);

        rand_dly = 1'b1;
        for (int j = 0; j < 10; j++) begin
            px = 16'($urandom_range(0, 65535));
            if ((4 + j) % 3 == 0) exp_q.push_back(9'h02C);
            exp_q.push_back({1'b1, px[15:8]});
            exp_q.push_back({1'b1, px[7:0]});
            send_pix(px, int'($urandom_range(0, 3)));
        end
        wait_log("bp_log", 56 + exp_q.size(), 5000);
        repeat (40) step();
        chk("bp_no_dup", lq.size(), 56 + exp_q.size());
        foreach (exp_q[i]) chk("bp_byte", lq[56 + i], exp_q[i]);
        chk("no_overlap", overlap, 0);
        chk("ready_while_busy", ready_viol, 0);
        chk("bp_fs_count", fs_cnt, 5);

        rand_dly = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stream", lcd_rst_n, 0);
        step();
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        base = lq.size();
        wait_log("reinit_20", base + 20, 2000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_lcd", lcd_rst_n, 0);
        chk("async_rst_addr", rom_addr, 47);
        chk("async_rst_init", init_done, 0);
        step();
        step();
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        base = lq.size();
        wait_init(init_cyc);
        chk("replay_count", lq.size() - base, 47);
        chk("replay_first", lq[base], 9'h0CB);
        chk("replay_last", lq[base + 46], 9'h02C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ili9341_cmd_sequencer.md
Name: ili9341_cmd_sequencer

Overview:
- Top-level controller for the ILI9341 panel link.
- Sequence: hardware reset pulse, then walks the 10-bit init command ROM, waits after Sleep-Out, then streams 16-bit RGB565 pixels as byte pairs.
- Every byte goes to the existing SPI byte shifter through a load/done handshake.
- Re-issues Memory Write (0x2C) at every frame boundary.

Parameters:
- ROM_DEPTH, 48: init ROM entries. Index ROM_DEPTH-1 is sent first; index 0 holds the terminator.
- RST_LOW_CYC, 16: cycles lcd_rst_n is held low.
- RST_WAIT_CYC, 32: cycles after lcd_rst_n rises before the first command.
- SLPOUT_WAIT_CYC, 64: wait cycles after byte 0x11 (Sleep Out) completes.
- PIXELS_PER_FRAME, 76800: pixels per frame before 0x2C is re-issued.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: level; leaving IDLE requires start=1.
- rom_addr, out, $clog2(ROM_DEPTH): init ROM index.
- rom_data, in, 10: combinational ROM entry. [9] loop flag (ignored), [8] D/C, [7:0] byte.
- byte_data, out, 8: byte presented to the shifter.
- byte_dc, out, 1: D/C for that byte (0 = command, 1 = data).
- byte_load, out, 1: one-cycle pulse; shifter captures byte_data/byte_dc.
- byte_done, in, 1: one-cycle pulse from the shifter when the byte is fully shifted out.
- pix_data, in, 16: RGB565 pixel.
- pix_valid, in, 1: pixel available.
- pix_ready, out, 1: pixel accepted when pix_valid and pix_ready are both 1.
- lcd_rst_n, out, 1: panel hardware reset.
- init_done, out, 1: level, high once streaming starts.
- frame_start, out, 1: one-cycle pulse on each 0x2C issue.

Behaviour:
- Reset values:
  - state IDLE; lcd_rst_n=0, byte_load=0, byte_data=0, byte_dc=0, pix_ready=0, init_done=0, frame_start=0.
  - rom_addr=ROM_DEPTH-1; all counters 0.
- IDLE: hold lcd_rst_n=0. If start=1, clear the delay counter and go to HW_RST.
- HW_RST: lcd_rst_n=0 for exactly RST_LOW_CYC cycles, then go to RST_WAIT with lcd_rst_n=1.
- RST_WAIT: count RST_WAIT_CYC cycles, then go to INIT_FETCH.
- INIT_FETCH: terminator check on rom_data at rom_addr.
  - If rom_data[8:0] == {0, 8'hFF}, or rom_addr == 0, go to STREAM: init_done=1, frame_start pulses, pixel counter cleared.
  - Otherwise, in the same cycle: byte_data=rom_data[7:0], byte_dc=rom_data[8], byte_load=1; go to INIT_WAIT.
- INIT_WAIT: wait for byte_done.
  - On byte_done, decrement rom_addr.
  - If the byte just sent was command 0x11, go to SLP_WAIT; otherwise go to INIT_FETCH.
- SLP_WAIT: count SLPOUT_WAIT_CYC cycles, then go to INIT_FETCH.
- STREAM, pixel transfer:
  - pix_ready=1 only when the shifter is idle (no byte outstanding) and the sub-state is HI.
  - On handshake, latch pix_data, load the high byte (dc=1), go to SUB_LO.
  - After byte_done, load the low byte (dc=1).
  - After the second byte_done, increment the pixel counter.
- STREAM, frame boundary:
  - When the pixel counter reaches PIXELS_PER_FRAME, load command 0x2C (dc=0), pulse frame_start, clear the counter.
  - Wait for byte_done, then resume pixels.
- Latency: byte_load is issued the cycle after a state entry or after byte_done, never on the same cycle as byte_done. One byte is outstanding at most.
- pix_valid low: stay in STREAM idle with no loads; the panel tolerates gaps.
- Shifter: byte_done while no byte is outstanding is ignored. byte_load must never be asserted while waiting.
- Reset: rst_n low at any point immediately returns all state to reset values. lcd_rst_n drops to 0 asynchronously. The init sequence restarts in full after release and start.
- start low after leaving IDLE has no effect.
- Counter widths are sized by $clog2 of the largest parameter plus 1. No wrap occurs before comparison.

Test Plan:
- Reset/pulse timing (RST_LOW_CYC=4, RST_WAIT_CYC=6): assert start → lcd_rst_n low exactly 4 cycles after start is seen, high, first byte_load exactly 6 cycles later.
- Init walk (shifter model with 3-cycle byte_done): 47 byte_loads in ROM order (0xCB first, 0x2C last, D/C matching bit 8); 0xFF terminator never loaded; init_done rises after the last done.
- Sleep-out delay (SLPOUT_WAIT_CYC=10): gap between byte_done of 0x11 and the next byte_load equals 10 cycles + 1.
- Pixel stream (PIXELS_PER_FRAME=3): pixels 0xF800, 0x07E0, 0x001F, 0xFFFF → bytes F8,00,07,E0,00,1F (dc=1), then 0x2C (dc=0) with a frame_start pulse, then FF,FF.
- Back-pressure: pix_valid toggled randomly, byte_done delayed 1–20 cycles → no byte_load while a byte is outstanding; no pixel lost or duplicated.
- Reset mid-init (rst_n low during byte 20, then start) → lcd_rst_n immediately 0, rom_addr back to 47, full sequence replays from 0xCB.
